dequant_scheduler: RTL and testbench
====================================

# dequant_scheduler

Shares one `dequantize` multiplier between `NUM_CH` requesting channels. Holds a per-channel Q16.16 scale register file and arbitrates round-robin among channels with valid input words. Drives the multiplier's `data_in`/`scale`/`en` and returns each result tagged with its channel. `mult_en` freezes the multiplier and the tag pipeline together under output backpressure. Sits between the accumulator/requant lanes and the single DSP-mapped `dequantize` instance.

## Interface
- `NUM_CH`, 4: number of requesting channels, 2..16.
- `LATENCY`, 1: register stages inside the attached multiplier, measured from `mult_en`-qualified input to `mult_result`.
- `CH_W`, $clog2(NUM_CH): channel index width.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: scale write strobe.
- `cfg_ch` in CH_W: channel whose scale is written.
- `cfg_scale` in 32: signed Q16.16 scale value.
- `in_valid` in NUM_CH: per-channel request.
- `in_data` in NUM_CH*32: per-channel signed word; channel i occupies bits [32i+31:32i].
- `in_ready` out NUM_CH: one-hot grant; a transfer occurs when `in_valid[i] && in_ready[i]`.
- `mult_en` out 1: drives the multiplier `en` input.
- `mult_data` out 32: drives the multiplier `data_in` input.
- `mult_scale` out 32: drives the multiplier `scale` input.
- `mult_result` in 32: multiplier `data_out`, equal to (data*scale)[47:16].
- `out_valid` out 1: result available.
- `out_ch` out CH_W: channel tag of the result.
- `out_data` out 32: equals `mult_result`.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: any valid entry in the tag pipeline.

## Operation
- Scale file: NUM_CH x 32 registers, each reset to 32'h0001_0000 (1.0). A write with `cfg_we` lands at the clock edge.
  - A grant in the same cycle as a write to the same channel uses the old scale.
- Stall: `stall = out_valid && !out_ready`. `mult_en = !stall`.
- Arbiter: round-robin pointer `last`, reset to NUM_CH-1.
  - Search starts at `last+1` (wrapping) and grants the first channel with `in_valid` set.
  - No grant and `in_ready` = 0 when `stall` is high.
  - `last` updates to the granted channel only on a transfer.
- Grant is combinational from `in_valid` and the current state. `in_ready[i]` must not require `in_valid[i]` to wait for ready.
- Multiplier drive (combinational):
  - `mult_data` = `in_data` of the granted channel.
  - `mult_scale` = scale of the granted channel.
  - With no grant, both are 0.
- Tag pipeline: LATENCY stages of {valid, ch}. Advances only when `mult_en` = 1.
  - Stage 0 loads {transfer, granted ch}.
  - When the pipeline advances with no transfer, a bubble (valid = 0) enters.
- Outputs:
  - `out_valid` / `out_ch` = last tag stage.
  - `out_data` = `mult_result`, passed through combinationally.
- `busy` = OR of all tag-stage valid bits.
- Reset (`rst_n` low, at any time):
  - tags cleared, so `out_valid` = 0, `out_ch` = 0, `busy` = 0;
  - `last` = NUM_CH-1;
  - scales = 1.0.
  - Any in-flight results are discarded. The multiplier's own reset is the integrator's concern.

## Timing
- A transfer at edge t gives `out_valid` = 1 after edge t+LATENCY-1+1, i.e. LATENCY cycles later, assuming no stall.
- Throughput: one result per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, all of `out_valid`, `out_ch` and `out_data` hold stable until accepted; this is guaranteed by the frozen multiplier register.
- On the cycle the stalled result is accepted, a new grant is allowed; results and grants run back-to-back with no bubble.
- Single requester held valid: granted every cycle.
- All NUM_CH valid: grants in strict rotation, each channel once per NUM_CH cycles.
- Reset deassertion: first grant can happen in the first cycle after `rst_n` rises.

## Test plan
- **Default scale.** After reset, ch0 `in_data` = 32'd5, `out_ready` = 1 → after LATENCY cycles `out_valid` = 1, `out_ch` = 0, `out_data` = 5.
- **Configured scale.** Write cfg ch2 = 32'h0000_8000 (0.5), then ch2 data = -32'd8 → `out_data` = -4, `out_ch` = 2.
  - Same-cycle write plus grant on ch2 → result uses the old scale.
- **Round robin.** All 4 channels valid continuously, data = channel id + 10 → grant order 0,1,2,3,0,…; `out_ch` sequence matches; `out_data` = 10,11,12,13.
- **Backpressure.**
  - Hold `out_ready` = 0 for 3 cycles with ch1 result pending → `out_valid`/`out_data` stable, `in_ready` = 0, `mult_en` = 0.
  - Release → pending result accepted and next grant in the same cycle.
- **Mid-operation reset.** Assert `rst_n` low while `busy` = 1 → `out_valid` = 0 immediately (async), scales back to 1.0, next grant after release goes to ch0.
- **Extreme values.** Data 32'h7FFF_FFFF × scale 32'h0002_0000 → `out_data` = (product)[47:16] = 32'hFFFF_FFFE, with no saturation applied.

Source files
------------

// File: rtl/dequant_scheduler.sv
// dequant_scheduler: shares one dequantize multiplier between NUM_CH channels.
// Holds a per-channel Q16.16 scale file and round-robin arbitrates the
// requesting channels. It also carries a {valid, ch} tag alongside the
// multiplier, so each result leaves tagged with the channel that produced it.
module dequant_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int LATENCY = 1,
   parameter int CH_W    = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [31:0]          cfg_scale,
   input  logic [NUM_CH-1:0]    in_valid,
   input  logic [NUM_CH*32-1:0] in_data,
   output logic [NUM_CH-1:0]    in_ready,
   output logic                 mult_en,
   output logic [31:0]          mult_data,
   output logic [31:0]          mult_scale,
   input  logic [31:0]          mult_result,
   output logic                 out_valid,
   output logic [CH_W-1:0]      out_ch,
   output logic [31:0]          out_data,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam logic [31:0] SCALE_ONE = 32'h0001_0000;

   logic [31:0]        r_scale [NUM_CH];
   logic [CH_W-1:0]    r_last;
   logic [LATENCY-1:0] r_tag_vld;
   logic [CH_W-1:0]    r_tag_ch [LATENCY];

   logic               w_stall;
   logic               w_grant_vld;
   logic [CH_W-1:0]    w_grant_ch;

   // A result the consumer refuses freezes the multiplier, the tags and the arbiter.
   assign w_stall = out_valid && !out_ready;
   assign mult_en = !w_stall;

   // Round-robin search: channels above r_last first, then wrap to channel 0.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_grant_vld = 1'b0;
      w_grant_ch  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_grant_vld && in_valid[i] && (i > int'(r_last))) begin
            w_grant_vld = 1'b1;
            w_grant_ch  = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_grant_vld && in_valid[i] && (i <= int'(r_last))) begin
            w_grant_vld = 1'b1;
            w_grant_ch  = CH_W'(i);
         end
      end
      if (w_stall) begin
         w_grant_vld = 1'b0;
         w_grant_ch  = '0;
      end
   end

   // The grant is only raised for a valid channel, so a grant is always a transfer.
   assign in_ready   = w_grant_vld ? (NUM_CH'(1) << w_grant_ch) : '0;
   assign mult_data  = w_grant_vld ? in_data[32*w_grant_ch +: 32] : '0;
   assign mult_scale = w_grant_vld ? r_scale[w_grant_ch] : '0;

   // Scale register file. A same-cycle grant reads the value from before the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this small file is reset on purpose because every channel must start at a scale of 1.0. Bulk data memories would be left unreset.
         for (int i = 0; i < NUM_CH; i++) r_scale[i] <= SCALE_ONE;
      end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
         // NOTE: non-blocking assignment, so every reader in this cycle sees the pre-edge value.
         r_scale[cfg_ch] <= cfg_scale;
      end
   end

   // The round-robin pointer moves only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= CH_W'(NUM_CH - 1);
      end else if (w_grant_vld) begin
         r_last <= w_grant_ch;
      end
   end

   // The tag pipeline mirrors the multiplier stages and advances with mult_en.
   // A reset drops any results still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= '0;
         for (int s = 0; s < LATENCY; s++) r_tag_ch[s] <= '0;
      end else if (mult_en) begin
         r_tag_vld[0] <= w_grant_vld;
         r_tag_ch[0]  <= w_grant_ch;
         for (int s = 1; s < LATENCY; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_ch[s]  <= r_tag_ch[s-1];
         end
      end
   end

   assign out_valid = r_tag_vld[LATENCY-1];
   assign out_ch    = r_tag_ch[LATENCY-1];
   assign out_data  = mult_result;
   assign busy      = |r_tag_vld;

endmodule

// File: tb/tb_dequant_scheduler.sv
// Bench for dequant_scheduler. It holds a behavioural multiplier and a
// queue-based reference model of arbitration, scale storage and result order.
module tb_dequant_scheduler;

   localparam int NUM_CH  = 4;
   localparam int LATENCY = 1;
   localparam int CH_W    = $clog2(NUM_CH);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 cfg_we = 1'b0;
   logic [CH_W-1:0]      cfg_ch = '0;
   logic [31:0]          cfg_scale = '0;
   logic [NUM_CH-1:0]    in_valid = '0;
   logic [NUM_CH*32-1:0] in_data = '0;
   logic [NUM_CH-1:0]    in_ready;
   logic                 mult_en;
   logic [31:0]          mult_data;
   logic [31:0]          mult_scale;
   logic [31:0]          mult_result;
   logic                 out_valid;
   logic [CH_W-1:0]      out_ch;
   logic [31:0]          out_data;
   logic                 out_ready = 1'b1;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dequant_scheduler #(.NUM_CH(NUM_CH), .LATENCY(LATENCY), .CH_W(CH_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_scale(cfg_scale),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mult_en(mult_en), .mult_data(mult_data), .mult_scale(mult_scale),
      .mult_result(mult_result),
      .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
      .out_ready(out_ready), .busy(busy)
   );

   // Q16.16 dequantize: signed 64-bit product, bits [47:16], no saturation.
   function automatic logic [31:0] prod(input logic [31:0] d, input logic [31:0] s);
      logic signed [63:0] p;
      p = $signed(d) * $signed(s);
      return p[47:16];
   endfunction

   // Behavioural multiplier: LATENCY registers, frozen when en is low.
   logic [31:0] mult_pipe [LATENCY];
   initial for (int s = 0; s < LATENCY; s++) mult_pipe[s] = '0;
   always @(posedge clk) begin
      if (mult_en) begin
         mult_pipe[0] <= prod(mult_data, mult_scale);
         for (int s = 1; s < LATENCY; s++) mult_pipe[s] <= mult_pipe[s-1];
      end
   end
   assign mult_result = mult_pipe[LATENCY-1];

   // Reference model: ordered queue of expected results, each with its age in cycles.
   typedef struct {
      int          ch;
      logic [31:0] data;
      int          age;
   } exp_t;

   exp_t        m_q[$];
   int          m_last;
   logic [31:0] m_scale [NUM_CH];

   task automatic model_reset();
      m_q.delete();
      m_last = NUM_CH - 1;
      for (int i = 0; i < NUM_CH; i++) m_scale[i] = 32'h0001_0000;
   endtask

   function automatic bit exp_valid();
      return (m_q.size() > 0) && (m_q[0].age == LATENCY);
   endfunction

   function automatic int exp_grant();
      if (exp_valid() && !out_ready) return -1;
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (m_last + k) % NUM_CH;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_ready();
      int g;
      g = exp_grant();
      return (g < 0) ? '0 : (NUM_CH'(1) << g);
   endfunction

   // Advance one clock and update the model from the inputs present at that edge.
   task automatic tick();
      int   g;
      bit   st;
      exp_t e;
      g  = exp_grant();
      st = exp_valid() && !out_ready;
      @(posedge clk);
      if (!st) begin
         if (exp_valid()) void'(m_q.pop_front());
         foreach (m_q[i]) m_q[i].age++;
         if (g >= 0) begin
            e.ch   = g;
            e.data = prod(in_data[32*g +: 32], m_scale[g]);
            e.age  = 1;
            m_q.push_back(e);
         end
      end
      if (g >= 0) m_last = g;
      if (cfg_we) m_scale[cfg_ch] = cfg_scale;
      #1;
   endtask

   task automatic set_ch(input int c, input bit v, input logic [31:0] d);
      in_valid[c]        = v;
      in_data[32*c +: 32] = d;
   endtask

   task automatic idle_inputs();
      in_valid = '0;
      in_data  = '0;
      cfg_we   = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      out_ready = 1'b1;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_checks++; if (out_ch !== '0) begin n_fail++; $display("FAIL reset_out_ch: got %0d exp 0", out_ch); end
      n_checks++; if (mult_en !== 1'b1) begin n_fail++; $display("FAIL reset_mult_en: got %b exp 1", mult_en); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_default_scale();
      out_ready = 1'b1;
      set_ch(0, 1'b1, 32'd5);
      #1;
      n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL default_grant: got %b exp 0001", in_ready); end
      n_checks++; if (mult_scale !== 32'h0001_0000) begin n_fail++; $display("FAIL default_scale: got %h exp 00010000", mult_scale); end
      tick();
      set_ch(0, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL default_valid: got %b exp 1", out_valid); end
      n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL default_ch: got %0d exp 0", out_ch); end
      n_checks++; if (out_data !== 32'd5) begin n_fail++; $display("FAIL default_data: got %h exp 5", out_data); end
      tick();
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL default_drained: got %b exp 0", out_valid); end
   endtask

   task automatic test_cfg_scale();
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_scale = 32'h0000_8000;
      tick();
      cfg_we = 1'b0;
      set_ch(2, 1'b1, -32'sd8);
      #1;
      n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL cfg_grant: got %b exp 0100", in_ready); end
      tick();
      set_ch(2, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL cfg_ch: got %0d exp 2", out_ch); end
      n_checks++; if (out_data !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL cfg_data: got %h exp fffffffc", out_data); end
      tick();
      // Write 2.0 in the same cycle as a grant: that result must still use 0.5.
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_scale = 32'h0002_0000;
      set_ch(2, 1'b1, 32'd6);
      tick();
      cfg_we = 1'b0;
      set_ch(2, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++; if (out_data !== 32'd3) begin n_fail++; $display("FAIL cfg_same_cycle_old: got %h exp 3", out_data); end
      tick();
      set_ch(2, 1'b1, 32'd6);
      tick();
      set_ch(2, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++; if (out_data !== 32'd12) begin n_fail++; $display("FAIL cfg_new_scale: got %h exp c", out_data); end
      tick();
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 32'(c + 10));
      for (int k = 0; k < 12; k++) begin
         #1;
         n_checks++;
         if (in_ready !== (NUM_CH'(1) << (k % NUM_CH))) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b exp one-hot %0d", k, in_ready, k % NUM_CH);
         end
         if (k >= LATENCY) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== CH_W'((k - LATENCY) % NUM_CH) ||
                out_data !== 32'(10 + (k - LATENCY) % NUM_CH)) begin
               n_fail++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%0d exp ch=%0d d=%0d",
                                  k, out_valid, out_ch, out_data, (k - LATENCY) % NUM_CH, 10 + (k - LATENCY) % NUM_CH);
            end
         end
         tick();
      end
      idle_inputs();
      repeat (LATENCY) tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      set_ch(1, 1'b1, 32'd7);
      #1;
      n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_grant: got %b exp 0010", in_ready); end
      tick();
      set_ch(1, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      out_ready = 1'b0;
      set_ch(1, 1'b1, 32'd8);
      set_ch(3, 1'b1, 32'd9);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 32'd7) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0d exp v=1 ch=1 d=7", k, out_valid, out_ch, out_data);
         end
         n_checks++;
         if (in_ready !== 4'b0000 || mult_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_frozen[%0d]: got ready=%b en=%b exp 0000 0", k, in_ready, mult_en);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b1000 || mult_en !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got ready=%b en=%b v=%b exp 1000 1 1", in_ready, mult_en, out_valid);
      end
      tick();
      idle_inputs();
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 32'd9) begin
         n_fail++; $display("FAIL bp_next: got v=%b ch=%0d d=%0d exp v=1 ch=3 d=9", out_valid, out_ch, out_data);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_scale = 32'h0003_0000;
      tick();
      cfg_we = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 32'(20 + c));
      tick();
      tick();
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b exp 1", busy); end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_ch !== '0) begin
         n_fail++; $display("FAIL mid_async_clear: got v=%b busy=%b ch=%0d exp 0 0 0", out_valid, busy, out_ch);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      set_ch(0, 1'b1, 32'd9);
      set_ch(1, 1'b1, 32'd4);
      #1;
      n_checks++;
      if (in_ready !== 4'b0001 || mult_scale !== 32'h0001_0000) begin
         n_fail++; $display("FAIL mid_after_release: got ready=%b scale=%h exp 0001 00010000", in_ready, mult_scale);
      end
      tick();
      idle_inputs();
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++;
      if (out_ch !== 2'd0 || out_data !== 32'd9) begin
         n_fail++; $display("FAIL mid_result: got ch=%0d d=%h exp ch=0 d=9", out_ch, out_data);
      end
      tick();
   endtask

   task automatic test_extreme();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_scale = 32'h0002_0000;
      tick();
      cfg_we = 1'b0;
      set_ch(1, 1'b1, 32'h7FFF_FFFF);
      #1;
      n_checks++;
      if (mult_data !== 32'h7FFF_FFFF || mult_scale !== 32'h0002_0000) begin
         n_fail++; $display("FAIL ext_drive: got data=%h scale=%h exp 7fffffff 00020000", mult_data, mult_scale);
      end
      tick();
      set_ch(1, 1'b0, 32'd0);
      repeat (LATENCY - 1) tick();
      #1;
      n_checks++;
      if (out_ch !== 2'd1 || out_data !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL ext_result: got ch=%0d d=%h exp ch=1 d=fffffffe", out_ch, out_data);
      end
      tick();
   endtask

   task automatic test_random();
      int g;
      for (int n = 0; n < 400; n++) begin
         in_valid  = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
         for (int c = 0; c < NUM_CH; c++) in_data[32*c +: 32] = $urandom();
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
         cfg_scale = $urandom();
         #1;
         g = exp_grant();
         n_checks++;
         if (in_ready !== exp_ready() || mult_en !== !(exp_valid() && !out_ready)) begin
            n_fail++; $display("FAIL rnd_grant[%0d]: got ready=%b en=%b exp ready=%b en=%b",
                               n, in_ready, mult_en, exp_ready(), !(exp_valid() && !out_ready));
         end
         n_checks++;
         if (out_valid !== exp_valid() || busy !== (m_q.size() != 0)) begin
            n_fail++; $display("FAIL rnd_valid[%0d]: got v=%b busy=%b exp v=%b busy=%b",
                               n, out_valid, busy, exp_valid(), m_q.size() != 0);
         end
         if (exp_valid()) begin
            n_checks++;
            if (out_ch !== CH_W'(m_q[0].ch) || out_data !== m_q[0].data) begin
               n_fail++; $display("FAIL rnd_result[%0d]: got ch=%0d d=%h exp ch=%0d d=%h",
                                  n, out_ch, out_data, m_q[0].ch, m_q[0].data);
            end
         end
         if (g >= 0) begin
            n_checks++;
            if (mult_data !== in_data[32*g +: 32] || mult_scale !== m_scale[g]) begin
               n_fail++; $display("FAIL rnd_drive[%0d]: got data=%h scale=%h exp data=%h scale=%h",
                                  n, mult_data, mult_scale, in_data[32*g +: 32], m_scale[g]);
            end
         end
         tick();
      end
      idle_inputs();
      out_ready = 1'b1;
      repeat (LATENCY + 2) tick();
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rnd_drain: got busy=%b v=%b exp 0 0", busy, out_valid);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default_scale();
      test_cfg_scale();
      test_round_robin();
      test_backpressure();
      test_mid_reset();
      test_extreme();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
